// File: rtl/cr16_mmio_responder_if.sv
// CR16 external memory bus as seen by a memory-mapped slave.
// read_data is registered by the slave and is valid one cycle after the address.
interface cr16_mmio_responder_if;
   logic [15:0] address;
   logic [15:0] write_data;
   logic        write_enable;
   logic [15:0] read_data;

   modport master (
      output address,
      output write_data,
      output write_enable,
      input  read_data
   );

   modport slave (
      input  address,
      input  write_data,
      input  write_enable,
      output read_data
   );
endinterface

// File: rtl/cr16_mmio_responder.sv
// MMIO responder for the CR16 external bus: switches, button edges, LEDs,
// 7-seg display bits and a prescaled timer with compare flag. Reads mirror BRAM port A timing.
module cr16_mmio_responder #(
   parameter logic [15:0] P_BASE_ADDRESS   = 16'hFF00,
   parameter int          P_TIMER_PRESCALE = 50000,
   parameter int          P_NUM_SWITCHES   = 10,
   parameter int          P_NUM_BUTTONS    = 4
) (
   input  logic                      I_CLK,
   input  logic                      I_NRESET,
   cr16_mmio_responder_if.slave      ext_mem,
   input  logic [P_NUM_SWITCHES-1:0] I_SWITCHES,
   input  logic [P_NUM_BUTTONS-1:0]  I_NBUTTONS,
   output logic [9:0]                O_LEDS,
   output logic [23:0]               O_DISPLAY_BITS,
   output logic                      O_TIMER_IRQ
);

   localparam int               PRE_W    = $clog2(P_TIMER_PRESCALE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(P_TIMER_PRESCALE - 1);

   localparam logic [3:0] OFS_SWITCHES = 4'h0;
   localparam logic [3:0] OFS_BTN_EDGE = 4'h1;
   localparam logic [3:0] OFS_LEDS     = 4'h2;
   localparam logic [3:0] OFS_DISP_LO  = 4'h3;
   localparam logic [3:0] OFS_DISP_HI  = 4'h4;
   localparam logic [3:0] OFS_TIMER    = 4'h5;
   localparam logic [3:0] OFS_COMPARE  = 4'h6;
   localparam logic [3:0] OFS_STATUS   = 4'h7;

   logic [P_NUM_SWITCHES-1:0] sw_meta;
   logic [P_NUM_SWITCHES-1:0] sw_sync;
   logic [P_NUM_BUTTONS-1:0]  btn_meta;
   logic [P_NUM_BUTTONS-1:0]  btn_sync;
   logic [P_NUM_BUTTONS-1:0]  btn_prev;
   logic [P_NUM_BUTTONS-1:0]  btn_edge;
   logic [9:0]                leds;
   logic [23:0]               disp;
   logic [PRE_W-1:0]          prescale;
   logic [15:0]               timer_count;
   logic [15:0]               compare;
   logic                      timer_match;
   logic [15:0]               read_data;

   logic                      hit;
   logic [3:0]                offset;
   logic                      wr;
   logic                      wr_btn_edge;
   logic                      wr_leds;
   logic                      wr_disp_lo;
   logic                      wr_disp_hi;
   logic                      wr_timer;
   logic                      wr_compare;
   logic                      wr_status;
   logic                      tick;
   logic                      match_set;
   logic                      match_clr;
   logic [P_NUM_BUTTONS-1:0]  btn_fall;
   logic [P_NUM_BUTTONS-1:0]  btn_clr;
   logic [15:0]               rd_value;

   assign hit    = (ext_mem.address[15:4] == P_BASE_ADDRESS[15:4]);
   assign offset = ext_mem.address[3:0];
   assign wr     = ext_mem.write_enable && hit;

   assign wr_btn_edge = wr && (offset == OFS_BTN_EDGE);
   assign wr_leds     = wr && (offset == OFS_LEDS);
   assign wr_disp_lo  = wr && (offset == OFS_DISP_LO);
   assign wr_disp_hi  = wr && (offset == OFS_DISP_HI);
   assign wr_timer    = wr && (offset == OFS_TIMER);
   assign wr_compare  = wr && (offset == OFS_COMPARE);
   assign wr_status   = wr && (offset == OFS_STATUS);

   assign btn_fall = btn_prev & ~btn_sync;
   assign btn_clr  = wr_btn_edge ? ext_mem.write_data[P_NUM_BUTTONS-1:0] : '0;

   // A TIMER write suppresses both the tick increment and the compare match on that edge.
   assign tick      = (prescale == PRE_LAST);
   assign match_set = tick && !wr_timer && ((timer_count + 16'd1) == compare);
   assign match_clr = wr_status && ext_mem.write_data[0];

   always_comb begin
      rd_value = 16'h0000;
      if (hit) begin
         case (offset)
            OFS_SWITCHES: rd_value = 16'(sw_sync);
            OFS_BTN_EDGE: rd_value = 16'(btn_edge);
            OFS_LEDS:     rd_value = {6'b0, leds};
            OFS_DISP_LO:  rd_value = disp[15:0];
            OFS_DISP_HI:  rd_value = {8'b0, disp[23:16]};
            OFS_TIMER:    rd_value = timer_count;
            OFS_COMPARE:  rd_value = compare;
            OFS_STATUS:   rd_value = {14'b0, |btn_edge, timer_match};
            default:      rd_value = 16'h0000;
         endcase
      end
   end

   // Button sync flops reset to released so leaving reset never looks like a press.
   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '1;
         btn_sync <= '1;
         btn_prev <= '1;
         btn_edge <= '0;
      end else begin
         sw_meta  <= I_SWITCHES;
         sw_sync  <= sw_meta;
         btn_meta <= I_NBUTTONS;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
         btn_edge <= (btn_edge & ~btn_clr) | btn_fall;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         leds      <= '0;
         disp      <= '0;
         compare   <= '0;
         read_data <= '0;
      end else begin
         read_data <= rd_value;
         if (wr_leds)    leds         <= ext_mem.write_data[9:0];
         if (wr_disp_lo) disp[15:0]   <= ext_mem.write_data;
         if (wr_disp_hi) disp[23:16]  <= ext_mem.write_data[7:0];
         if (wr_compare) compare      <= ext_mem.write_data;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         prescale    <= '0;
         timer_count <= '0;
         timer_match <= 1'b0;
      end else begin
         if (wr_timer) begin
            prescale    <= '0;
            timer_count <= '0;
         end else if (tick) begin
            prescale    <= '0;
            timer_count <= timer_count + 16'd1;
         end else begin
            prescale    <= prescale + 1'b1;
         end
         timer_match <= match_set | (timer_match & ~match_clr);
      end
   end

   assign ext_mem.read_data = read_data;
   assign O_LEDS            = leds;
   assign O_DISPLAY_BITS    = disp;
   assign O_TIMER_IRQ       = timer_match;

endmodule
